snake_dir_ctrl: RTL

Upstream input stage for the snake game FSM: conditions the four active-low push-buttons into a debounced, reversal-safe movement direction. Accepted turns are buffered in a 2-entry turn queue. The game FSM pulses `step` once per move; on that pulse one queued turn is committed to the current direction. Registered one-hot `move_*` outputs replace the direct combinational KEY decode in the game FSM.

---
 rtl/snake_pkg.sv | 24 ++
 rtl/snake_dir_ctrl_if.sv | 33 +++
 rtl/key_debounce.sv | 61 ++++++
 rtl/snake_dir_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake game input stage and game FSM.
//   dir_t       2-bit movement direction (R=0, D=1, U=2, L=3)
//   opposite()  the reverse of a direction (bitwise d ^ 2'b11)
//   dir_onehot() direction to {left, up, down, right} one-hot vector
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_R = 2'd0;
    localparam dir_t DIR_D = 2'd1;
    localparam dir_t DIR_U = 2'd2;
    localparam dir_t DIR_L = 2'd3;

    // The encoding pairs R/L and D/U so that flipping both bits reverses.
    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b11;
    endfunction

    // Bit index equals the direction code: [0]=right [1]=down [2]=up [3]=left.
    function automatic logic [3:0] dir_onehot(input dir_t d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// snake_dir_ctrl_if: signal bundle between the game FSM side (master) and the
// direction controller (slave).
//   KEY[3:0]    raw active-low buttons: [0]=right [1]=down [2]=up [3]=left
//   step        single-cycle commit pulse from the game FSM
//   move_*      registered one-hot current direction (all 0 before first press)
//   started     set by the first accepted press
//   q_count     number of buffered turns (0..2)
//
// Handshake: step is a fire-and-forget strobe with no ready/acknowledge. Every
// cycle in which step is high is one commit request; the controller always
// consumes it in that cycle (popping a turn if one is queued, else no change).
interface snake_dir_ctrl_if;

    logic [3:0] KEY;
    logic       step;
    logic       move_right;
    logic       move_down;
    logic       move_up;
    logic       move_left;
    logic       started;
    logic [1:0] q_count;

    modport master (
        output KEY, step,
        input  move_right, move_down, move_up, move_left, started, q_count
    );

    modport slave (
        input  KEY, step,
        output move_right, move_down, move_up, move_left, started, q_count
    );

endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, counter debouncer and press detector for
// one active-low button.
//   CLOCK_50  clock
//   Resetn    synchronous active-low reset
//   key_n     raw asynchronous button level (0 = pressed)
//   press     one-cycle pulse on a debounced 1->0 transition
module key_debounce #(
    parameter int DB_BITS = 20
) (
    input  logic CLOCK_50,
    input  logic Resetn,
    input  logic key_n,
    output logic press
);

    localparam logic [DB_BITS-1:0] DB_MAX = '1;

    logic               sync1;
    logic               sync2;
    logic               stable;
    logic [DB_BITS-1:0] cnt;
    // fill1/fill2 mark when the synchronizer holds real pin data rather than
    // its reset value; armed then requires the key to be seen released once,
    // so a button held through reset cannot produce a press.
    logic               fill1;
    logic               fill2;
    logic               armed;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
            fill1  <= 1'b0;
            fill2  <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            fill1 <= 1'b1;
            fill2 <= fill1;
            press <= 1'b0;
            if (fill2 && sync2)
                armed <= 1'b1;

            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                stable <= sync2;
                cnt    <= '0;
                // stable differs from sync2 here, so stable==1 means a fall.
                press  <= armed & stable;
            end else begin
                cnt <= cnt + DB_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns four raw buttons into a debounced, reversal-safe
// snake direction with a 2-entry turn queue committed on each step pulse.
//   CLOCK_50  50 MHz clock
//   Resetn    synchronous active-low reset
//   io        slave side of snake_dir_ctrl_if (KEY, step in; move_*, started,
//             q_count out)
//   DB_BITS   debounce counter width (20 for hardware, 2 for simulation)
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int DB_BITS = 20
) (
    input  logic              CLOCK_50,
    input  logic              Resetn,
    snake_dir_ctrl_if.slave   io
);

    logic [3:0] press;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(.DB_BITS(DB_BITS)) u_db (
            .CLOCK_50 (CLOCK_50),
            .Resetn   (Resetn),
            .key_n    (io.KEY[k]),
            .press    (press[k])
        );
    end

    dir_t       q_mem [2];
    logic       hd;
    logic [1:0] cnt;
    dir_t       cur;
    logic       started;
    logic [3:0] move;

    dir_t cand;
    logic cand_valid;
    logic tail_idx;
    logic wr_idx;
    dir_t ref_dir;
    logic pop;
    logic push;

    always_comb begin
        cand       = DIR_R;
        cand_valid = |press;
        if (press[0])      cand = DIR_R;
        else if (press[1]) cand = DIR_D;
        else if (press[2]) cand = DIR_U;
        else if (press[3]) cand = DIR_L;

        // Tail is the newest entry: head for one entry, the other slot for two.
        tail_idx = hd ^ (cnt == 2'd2);
        // Next free slot: head when empty or full (full only matters with a pop).
        wr_idx   = hd ^ cnt[0];
        ref_dir  = (cnt != 2'd0) ? q_mem[tail_idx] : cur;

        pop  = io.step & started & (cnt != 2'd0);
        push = started & cand_valid
             & (cand != ref_dir) & (cand != opposite(ref_dir))
             & ((cnt != 2'd2) | pop);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            q_mem[0] <= DIR_R;
            q_mem[1] <= DIR_R;
            hd       <= 1'b0;
            cnt      <= 2'd0;
            cur      <= DIR_R;
            started  <= 1'b0;
            move     <= 4'b0000;
        end else begin
            // First press sets the direction directly; pop cannot happen then.
            if (!started && cand_valid) begin
                cur     <= cand;
                started <= 1'b1;
                move    <= dir_onehot(cand);
            end
            if (pop) begin
                cur  <= q_mem[hd];
                move <= dir_onehot(q_mem[hd]);
                hd   <= ~hd;
            end
            // With a full queue and a pop, wr_idx is the head being vacated.
            if (push)
                q_mem[wr_idx] <= cand;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

    assign io.move_right = move[0];
    assign io.move_down  = move[1];
    assign io.move_up    = move[2];
    assign io.move_left  = move[3];
    assign io.started    = started;
    assign io.q_count    = cnt;

endmodule
